// File: rtl/accum_datapath.sv
// Accumulator datapath: free-running program counter, combinational ALU and W/carry register.
// The ALU result is written back into W on every rising clock edge; opcodes 12-15 hold W.
module accum_datapath #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [3:0]       inst,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] counter,
  output logic [WIDTH:0]   ans,
  output logic [WIDTH-1:0] w,
  output logic             carry
);

  logic [WIDTH-1:0]   r_counter;
  logic [WIDTH-1:0]   r_w;
  logic               r_carry;

  logic [2:0]         w_sh;
  logic [WIDTH:0]     w_a_ext;
  logic [WIDTH:0]     w_b_ext;
  logic [WIDTH:0]     w_shl;
  logic [2*WIDTH-1:0] w_dbl;
  logic [WIDTH-1:0]   w_rol;
  logic [WIDTH-1:0]   w_ror;

  assign w_sh    = b[2:0];
  assign w_a_ext = {1'b0, r_w};
  assign w_b_ext = {1'b0, b};
  // Extended shift keeps the last bit pushed out of the MSB in the carry position.
  assign w_shl   = w_a_ext << w_sh;
  // Rotates are taken from a doubled copy of W.
  assign w_dbl   = {r_w, r_w};
  assign w_rol   = WIDTH'(w_dbl >> (WIDTH - w_sh));
  assign w_ror   = WIDTH'(w_dbl >> w_sh);

  always_comb begin
    ans = '0;
    if (!reset) begin
      case (inst)
        4'd0:    ans = w_b_ext;
        4'd1:    ans = w_a_ext + w_b_ext;
        4'd2:    ans = w_a_ext - w_b_ext;
        4'd3:    ans = {1'b0, r_w & b};
        4'd4:    ans = w_shl;
        4'd5:    ans = {1'b0, r_w >> w_sh};
        4'd6:    ans = {1'b0, r_w | b};
        4'd7:    ans = {1'b0, r_w ^ b};
        4'd8:    ans = {1'b0, ~r_w};
        4'd9:    ans = w_a_ext + {{WIDTH{1'b0}}, 1'b1};
        4'd10:   ans = {1'b0, w_rol};
        4'd11:   ans = {1'b0, w_ror};
        default: ans = w_a_ext;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_counter <= '0;
      r_w       <= '0;
      r_carry   <= 1'b0;
    end else begin
      r_counter <= r_counter + WIDTH'(1);
      r_w       <= ans[WIDTH-1:0];
      r_carry   <= ans[WIDTH];
    end
  end

  assign counter = r_counter;
  assign w       = r_w;
  assign carry   = r_carry;

endmodule

// File: tb/tb_accum_datapath.sv
// Self-checking bench for accum_datapath: directed scenarios plus randomized opcodes,
// compared against an arithmetic reference model of counter, W, carry and the ALU.
module tb_accum_datapath;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] inst = 4'd0;
  logic [7:0] b = 8'd0;
  logic [7:0] counter;
  logic [8:0] ans;
  logic [7:0] w;
  logic       carry;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference state
  int m_cnt   = 0;
  int m_w     = 0;
  int m_carry = 0;

  accum_datapath #(.WIDTH(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .inst    (inst),
    .b       (b),
    .counter (counter),
    .ans     (ans),
    .w       (w),
    .carry   (carry)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic int model_alu(input int a, input int op, input int bv);
    int sh;
    int r;
    sh = bv % 8;
    case (op)
      0:       r = bv;
      1:       r = a + bv;
      2:       r = (a - bv + 512) % 512;
      3:       r = a & bv;
      4:       r = (a * (1 << sh)) % 512;
      5:       r = a / (1 << sh);
      6:       r = a | bv;
      7:       r = a ^ bv;
      8:       r = 255 - a;
      9:       r = a + 1;
      10:      r = ((a * (1 << sh)) + (a / (1 << (8 - sh)))) % 256;
      11:      r = ((a / (1 << sh)) + (a * (1 << (8 - sh)))) % 256;
      default: r = a;
    endcase
    return r;
  endfunction

  // Called just after a falling edge with reset low: drive, check ans, clock once, check state.
  task automatic do_cycle(input int op, input int bv, input int exp_ans, input int exp_w);
    int r;
    inst = 4'(op);
    b    = 8'(bv);
    #1;
    r = model_alu(m_w, op, bv);
    check("ans", 32'(ans), 32'(r));
    if (exp_ans >= 0) check("ans_const", 32'(ans), 32'(exp_ans));
    @(posedge clk);
    m_cnt   = (m_cnt + 1) % 256;
    m_w     = r % 256;
    m_carry = r / 256;
    @(negedge clk);
    check("counter", 32'(counter), 32'(m_cnt));
    check("w", 32'(w), 32'(m_w));
    check("carry", 32'(carry), 32'(m_carry));
    if (exp_w >= 0) check("w_const", 32'(w), 32'(exp_w));
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_counter"}, 32'(counter), 32'd0);
    check({tag, "_w"}, 32'(w), 32'd0);
    check({tag, "_carry"}, 32'(carry), 32'd0);
    check({tag, "_ans"}, 32'(ans), 32'd0);
  endtask

  // Assert reset between clock edges and release it at the next falling edge.
  task automatic async_reset_pulse(input string tag);
    #2;
    reset = 1'b1;
    #1;
    check_cleared(tag);
    m_cnt = 0; m_w = 0; m_carry = 0;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    // Reset with a non-trivial opcode so ans=0 really comes from reset
    inst = 4'd0;
    b    = 8'd55;
    #1;
    reset = 1'b1;
    #2;
    check_cleared("por");
    @(negedge clk);
    check_cleared("por_held");
    reset = 1'b0;

    for (int i = 0; i < 3; i++) do_cycle(12, int'($urandom_range(0, 255)), -1, 0);
    check("cnt_after3", 32'(counter), 32'd3);

    do_cycle(0, 10, 10, 10);
    do_cycle(1, 10, 20, 20);
    do_cycle(1, 10, 30, 30);
    check("add_no_carry", 32'(carry), 32'd0);

    do_cycle(0, 250, -1, 250);
    do_cycle(1, 10, 'h104, 4);
    check("add_ovf_carry", 32'(carry), 32'd1);

    do_cycle(0, 3, -1, 3);
    do_cycle(2, 10, 'h1F9, 249);
    check("sub_borrow", 32'(carry), 32'd1);

    do_cycle(0, 3, -1, 3);
    do_cycle(4, 1, -1, 6);
    do_cycle(0, 'h81, -1, 'h81);
    do_cycle(4, 1, 'h102, 2);
    check("shl_carry", 32'(carry), 32'd1);
    do_cycle(0, 'h81, -1, 'h81);
    do_cycle(10, 1, -1, 'h03);
    do_cycle(0, 'h81, -1, 'h81);
    do_cycle(11, 1, -1, 'hC0);
    do_cycle(0, 'h81, -1, 'h81);
    do_cycle(5, 3, -1, 'h10);

    do_cycle(0, 3, -1, 3);
    do_cycle(6, 4, -1, 7);
    do_cycle(0, 3, -1, 3);
    do_cycle(7, 1, -1, 2);
    do_cycle(0, 3, -1, 3);
    do_cycle(3, 1, -1, 1);
    do_cycle(0, 3, -1, 3);
    do_cycle(8, 0, -1, 'hFC);
    for (int i = 0; i < 3; i++) do_cycle(12 + i, int'($urandom_range(0, 255)), -1, 'hFC);
    do_cycle(9, 0, 'hFD, 'hFD);

    // Reset mid-operation, no clock edge involved
    inst = 4'd1;
    b    = 8'd7;
    async_reset_pulse("midop");
    do_cycle(1, 7, 7, 7);

    // Reset released exactly on a rising edge: that edge must not count
    #2;
    reset = 1'b1;
    inst  = 4'd0;
    b     = 8'd99;
    #1;
    check_cleared("pre_coinc");
    @(posedge clk);
    reset <= 1'b0;
    @(negedge clk);
    check("coinc_counter", 32'(counter), 32'd0);
    check("coinc_w", 32'(w), 32'd0);
    m_cnt = 0; m_w = 0; m_carry = 0;

    // Counter wrap
    for (int i = 0; i < 256; i++) do_cycle(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), -1, -1);
    check("cnt_wrap", 32'(counter), 32'd0);

    // Randomized phase with occasional asynchronous resets
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 49) == 0) async_reset_pulse("rnd_rst");
      do_cycle(int'($urandom_range(0, 15)), int'($urandom_range(0, 255)), -1, -1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
